// File: rtl/mb_pkg.sv
// Shared constants and types for the mainband receive path.
package mb_pkg;

    localparam int MB_LANES       = 16;
    localparam int FLIT_BYTES     = 64;
    localparam int WORDS_PER_FLIT = 32;
    localparam int CNT_W          = $clog2(WORDS_PER_FLIT);

    typedef logic [7:0] flit_t [FLIT_BYTES-1:0];

    typedef enum logic {IDLE, RECV} rx_state_t;

endpackage

// File: rtl/mb_flit_fifo.sv
// Flit FIFO with wrap-bit pointers.
// The head flit is read combinationally from storage; it reads as zero while the FIFO is empty.
module mb_flit_fifo
    import mb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic  clk,
    input  logic  reset,
    input  logic  push,
    input  flit_t wdata,
    input  logic  pop_req,
    output logic  head_valid,
    output flit_t head_data,
    output logic  drop
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [AW:0] wr_ptr, rd_ptr;
    flit_t       mem [DEPTH];
    logic        empty, full, pop, wr;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
    assign pop   = pop_req && !empty;
    // A pop in the same cycle frees the slot a full-FIFO push needs.
    assign wr    = push && (!full || pop);
    assign drop  = push && !wr;

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr)  wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr) mem[wr_ptr[AW-1:0]] <= wdata;
    end

    assign head_valid = !empty;

    always_comb begin
        for (int i = 0; i < FLIT_BYTES; i++)
            head_data[i] = empty ? 8'h00 : mem[rd_ptr[AW-1:0]][i];
    end

endmodule

// File: rtl/mb_rx.sv
// Mainband receiver: deserializes 32 sampled 16-bit words into a 64-byte flit
// and queues completed flits for the upper layer.
module mb_rx
    import mb_pkg::*;
#(
    parameter int flit_buffer_size = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                valid_pin_i,
    input  logic [MB_LANES-1:0] dataPins_i,
    output logic                flit_valid_o,
    output flit_t               flit_data_o,
    input  logic                flit_ready_i,
    output logic                receiving_o,
    output logic                overflow_o,
    output logic                frame_err_o
);

    rx_state_t        state, next_state;
    logic [CNT_W-1:0] cnt;
    flit_t            flit_q, flit_w;
    logic             done, abort, drop;

    always_ff @(posedge clk) begin
        if (!reset) state <= IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (valid_pin_i) next_state = RECV;
            RECV:    if (!valid_pin_i || cnt == CNT_W'(WORDS_PER_FLIT-1)) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        done        = (state == RECV) && valid_pin_i && (cnt == CNT_W'(WORDS_PER_FLIT-1));
        abort       = (state == RECV) && !valid_pin_i;
        receiving_o = (state == RECV);
    end

    always_ff @(posedge clk) begin
        if (!reset)              cnt <= '0;
        else if (done || abort)  cnt <= '0;
        else if (valid_pin_i)    cnt <= cnt + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (valid_pin_i) begin
            flit_q[{cnt, 1'b0}] <= dataPins_i[7:0];
            flit_q[{cnt, 1'b1}] <= dataPins_i[15:8];
        end
    end

    // The last word joins the flit on its way into the FIFO, so the flit is visible right after word 31.
    always_comb begin
        flit_w                = flit_q;
        flit_w[FLIT_BYTES-2]  = dataPins_i[7:0];
        flit_w[FLIT_BYTES-1]  = dataPins_i[15:8];
    end

    mb_flit_fifo #(.DEPTH(flit_buffer_size)) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .push       (done),
        .wdata      (flit_w),
        .pop_req    (flit_ready_i),
        .head_valid (flit_valid_o),
        .head_data  (flit_data_o),
        .drop       (drop)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            overflow_o  <= 1'b0;
            frame_err_o <= 1'b0;
        end else begin
            overflow_o  <= drop;
            frame_err_o <= abort;
        end
    end

endmodule

// File: tb/tb_mb_rx.sv
// Directed bench for mb_rx: single flit, back-to-back, overflow, pop-on-full, frame error, mid-flit reset.
module tb_mb_rx;
    import mb_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        valid_pin_i;
    logic [15:0] dataPins_i;
    logic        flit_valid_o;
    flit_t       flit_data_o;
    logic        flit_ready_i;
    logic        receiving_o;
    logic        overflow_o;
    logic        frame_err_o;

    int checks = 0;
    int failures = 0;
    int ov_cnt = 0;
    int fe_cnt = 0;
    int ov0, fe0;
    logic [7:0] fb [64];

    mb_rx #(.flit_buffer_size(4)) dut (
        .clk          (clk),
        .reset        (reset),
        .valid_pin_i  (valid_pin_i),
        .dataPins_i   (dataPins_i),
        .flit_valid_o (flit_valid_o),
        .flit_data_o  (flit_data_o),
        .flit_ready_i (flit_ready_i),
        .receiving_o  (receiving_o),
        .overflow_o   (overflow_o),
        .frame_err_o  (frame_err_o)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (overflow_o === 1'b1)  ov_cnt++;
        if (frame_err_o === 1'b1) fe_cnt++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic fill(input logic [7:0] tag);
        for (int i = 0; i < 64; i++) fb[i] = tag + 8'(i);
    endtask

    task automatic send_range(input int lo, input int hi);
        for (int k = lo; k <= hi; k++) begin
            valid_pin_i = 1'b1;
            dataPins_i  = {fb[2*k+1], fb[2*k]};
            tick();
        end
    endtask

    initial begin
        string s;
        reset = 1'b0; valid_pin_i = 1'b0; dataPins_i = '0; flit_ready_i = 1'b0;
        repeat (3) tick();
        chk("rst_flit_valid", flit_valid_o, 0);
        chk("rst_receiving", receiving_o, 0);
        chk("rst_overflow", overflow_o, 0);
        chk("rst_frame_err", frame_err_o, 0);
        chk("rst_data0", flit_data_o[0], 0);
        reset = 1'b1;
        tick();

        // Single ASCII flit
        s = "Hello, World! This is a test. Flit 0";
        for (int i = 0; i < 64; i++) fb[i] = (i < s.len()) ? s[i] : 8'h20;
        send_range(0, 0);
        chk("hello_receiving_w0", receiving_o, 1);
        chk("hello_no_flit_yet", flit_valid_o, 0);
        send_range(1, 30);
        chk("hello_no_flit_w30", flit_valid_o, 0);
        send_range(31, 31);
        valid_pin_i = 1'b0;
        chk("hello_flit_valid", flit_valid_o, 1);
        chk("hello_receiving_done", receiving_o, 0);
        chk("hello_b0", flit_data_o[0], 8'h48);
        chk("hello_b1", flit_data_o[1], 8'h65);
        chk("hello_b35", flit_data_o[35], 8'h30);
        chk("hello_b63", flit_data_o[63], 8'h20);
        tick();
        chk("hello_hold", flit_data_o[0], 8'h48);
        flit_ready_i = 1'b1;
        tick();
        flit_ready_i = 1'b0;
        chk("hello_popped", flit_valid_o, 0);

        // Three back-to-back flits, consumer always ready
        ov0 = ov_cnt; fe0 = fe_cnt;
        flit_ready_i = 1'b1;
        for (int f = 0; f < 3; f++) begin
            fill(8'h10 * 8'(f + 1));
            send_range(0, 31);
            chk("b2b_valid", flit_valid_o, 1);
            chk("b2b_b0", flit_data_o[0], 8'h10 * 8'(f + 1));
            chk("b2b_b63", flit_data_o[63], 8'h10 * 8'(f + 1) + 8'd63);
        end
        valid_pin_i = 1'b0;
        tick();
        chk("b2b_drained", flit_valid_o, 0);
        chk("b2b_no_overflow", ov_cnt - ov0, 0);
        chk("b2b_no_frame_err", fe_cnt - fe0, 0);
        flit_ready_i = 1'b0;

        // Five flits into a depth-4 FIFO with no consumer
        ov0 = ov_cnt;
        for (int f = 0; f < 5; f++) begin
            fill(8'h40 + 8'h10 * 8'(f));
            send_range(0, 31);
            if (f < 4) chk("ovf_no_pulse", overflow_o, 0);
        end
        chk("ovf_pulse", overflow_o, 1);
        valid_pin_i = 1'b0;
        tick();
        chk("ovf_pulse_end", overflow_o, 0);
        chk("ovf_once", ov_cnt - ov0, 1);
        flit_ready_i = 1'b1;
        for (int j = 0; j < 4; j++) begin
            chk("ovf_drain_valid", flit_valid_o, 1);
            chk("ovf_drain_b0", flit_data_o[0], 8'h40 + 8'h10 * 8'(j));
            tick();
        end
        chk("ovf_drain_empty", flit_valid_o, 0);
        flit_ready_i = 1'b0;

        // Full FIFO; fifth flit completes together with a pop
        ov0 = ov_cnt;
        for (int f = 0; f < 4; f++) begin
            fill(8'hA0 + 8'h10 * 8'(f));
            send_range(0, 31);
        end
        fill(8'hE0);
        send_range(0, 30);
        chk("pof_head_a0", flit_data_o[0], 8'hA0);
        flit_ready_i = 1'b1;
        send_range(31, 31);
        valid_pin_i = 1'b0;
        chk("pof_no_overflow", overflow_o, 0);
        for (int j = 0; j < 4; j++) begin
            chk("pof_drain_valid", flit_valid_o, 1);
            chk("pof_drain_b0", flit_data_o[0], 8'hB0 + 8'h10 * 8'(j));
            tick();
        end
        chk("pof_empty", flit_valid_o, 0);
        chk("pof_ov_count", ov_cnt - ov0, 0);

        // Valid drops after 10 words
        fe0 = fe_cnt;
        fill(8'h11);
        send_range(0, 9);
        chk("fe_receiving", receiving_o, 1);
        valid_pin_i = 1'b0;
        tick();
        chk("fe_pulse", frame_err_o, 1);
        chk("fe_no_flit", flit_valid_o, 0);
        chk("fe_receiving_off", receiving_o, 0);
        tick();
        chk("fe_pulse_end", frame_err_o, 0);
        chk("fe_once", fe_cnt - fe0, 1);
        fill(8'h22);
        send_range(0, 31);
        valid_pin_i = 1'b0;
        chk("fe_next_valid", flit_valid_o, 1);
        chk("fe_next_b0", flit_data_o[0], 8'h22);
        chk("fe_next_b19", flit_data_o[19], 8'h35);
        tick();
        chk("fe_next_popped", flit_valid_o, 0);
        flit_ready_i = 1'b0;

        // Reset mid-flit with two flits buffered
        fill(8'h31); send_range(0, 31);
        fill(8'h41); send_range(0, 31);
        fill(8'h51); send_range(0, 19);
        chk("mr_buffered", flit_valid_o, 1);
        valid_pin_i = 1'b1;
        dataPins_i  = {fb[41], fb[40]};
        reset = 1'b0;
        tick();
        chk("mr_flit_valid", flit_valid_o, 0);
        chk("mr_receiving", receiving_o, 0);
        chk("mr_data0", flit_data_o[0], 0);
        reset = 1'b1;
        valid_pin_i = 1'b0;
        tick();
        fill(8'h61);
        send_range(0, 31);
        valid_pin_i = 1'b0;
        chk("mr_clean_valid", flit_valid_o, 1);
        chk("mr_clean_b0", flit_data_o[0], 8'h61);
        chk("mr_clean_b63", flit_data_o[63], 8'hA0);
        flit_ready_i = 1'b1;
        tick();
        chk("mr_only_flit", flit_valid_o, 0);
        flit_ready_i = 1'b0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
